// File: rtl/uart_cmd_master.sv
// Register-access master: frames read/write requests onto a UART byte stream and parses the reply.
// Build option UART_CMD_CRC_EN adds a CRC-8 trailer to both request and response frames.
module uart_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1_250_000,
    parameter logic [7:0]  SOF_TX         = 8'hA5,
    parameter logic [7:0]  SOF_RX         = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [7:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic        busy
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_CMD_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, TX_SOF, TX_CMD, TX_ADDR, TX_DATA, TX_CRC,
        RX_SOF, RX_STAT, RX_CMD, RX_DATA, RX_CRC, DONE
    } state_t;

    state_t           state, state_d;
    logic [1:0]       idx, idx_d;
    logic             write_q;
    logic [31:0]      addr_q, wdata_q, rdata_q, rdata_d;
    logic [7:0]       crc, crc_d, status_q, status_d, cmd;
    logic             echo_bad, echo_bad_d, crc_bad, crc_bad_d, tout, tout_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       tx_byte_d, rsp_status_d, final_status;
    logic [31:0]      rsp_rdata_d;
    logic             tx_valid_d, req_ready_d, busy_d, rsp_valid_d;
    logic             tx_fire, rx_state, timeout_hit;
    state_t           tx_tail, rx_tail;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    assign cmd         = {~write_q, 1'b0, 2'b10, 4'h0};
    assign tx_fire     = tx_valid && tx_ready;
    assign rx_state    = state inside {RX_SOF, RX_STAT, RX_CMD, RX_DATA, RX_CRC};
    assign timeout_hit = rx_state && !rx_valid && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tx_tail     = CRC_EN ? TX_CRC : RX_SOF;
    assign rx_tail     = CRC_EN ? RX_CRC : DONE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic; an rx byte always pre-empts a timeout in the same cycle
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_valid) state_d = TX_SOF;
            TX_SOF:  if (tx_fire) state_d = TX_CMD;
            TX_CMD:  if (tx_fire) state_d = TX_ADDR;
            TX_ADDR: if (tx_fire && idx == 2'd3) state_d = write_q ? TX_DATA : tx_tail;
            TX_DATA: if (tx_fire && idx == 2'd3) state_d = tx_tail;
            TX_CRC:  if (tx_fire) state_d = RX_SOF;
            RX_SOF:  if (rx_valid && rx_byte == SOF_RX) state_d = RX_STAT;
            RX_STAT: if (rx_valid) state_d = RX_CMD;
            RX_CMD:  if (rx_valid) state_d = (!write_q && status_q == 8'h00) ? RX_DATA : rx_tail;
            RX_DATA: if (rx_valid && idx == 2'd3) state_d = rx_tail;
            RX_CRC:  if (rx_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = DONE;
    end

    // Datapath and registered-output next values, derived from the next state
    always_comb begin
        idx_d        = idx;
        crc_d        = crc;
        status_d     = status_q;
        echo_bad_d   = echo_bad;
        crc_bad_d    = crc_bad;
        tout_d       = tout;
        rdata_d      = rdata_q;
        cnt_d        = '0;
        rsp_status_d = rsp_status;
        rsp_rdata_d  = rsp_rdata;
        final_status = 8'h00;
        tx_byte_d    = 8'h00;
        if (rx_state)
            cnt_d = rx_valid ? '0 : ((cnt == CNT_W'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1);
        case (state)
            IDLE: if (req_valid) begin
                idx_d = '0; crc_d = '0; status_d = '0; rdata_d = '0;
                echo_bad_d = 1'b0; crc_bad_d = 1'b0; tout_d = 1'b0;
            end
            TX_CMD: if (tx_fire) crc_d = crc8(crc, tx_byte);
            TX_ADDR, TX_DATA: if (tx_fire) begin
                crc_d = crc8(crc, tx_byte);
                idx_d = idx + 2'd1;
            end
            RX_STAT: if (rx_valid) begin
                status_d = rx_byte;
                crc_d    = crc8(crc, rx_byte);
            end
            RX_CMD: if (rx_valid) begin
                echo_bad_d = (rx_byte != cmd);
                crc_d      = crc8(crc, rx_byte);
            end
            RX_DATA: if (rx_valid) begin
                rdata_d[{idx, 3'b000} +: 8] = rx_byte;
                idx_d = idx + 2'd1;
                crc_d = crc8(crc, rx_byte);
            end
            RX_CRC: if (rx_valid) crc_bad_d = (rx_byte != crc);
            default: ;
        endcase
        if (timeout_hit) tout_d = 1'b1;
        if (state_d == RX_SOF && state != RX_SOF) crc_d = '0;

        tx_valid_d  = state_d inside {TX_SOF, TX_CMD, TX_ADDR, TX_DATA, TX_CRC};
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == DONE);
        case (state_d)
            TX_SOF:  tx_byte_d = SOF_TX;
            TX_CMD:  tx_byte_d = cmd;
            TX_ADDR: tx_byte_d = addr_q[{idx_d, 3'b000} +: 8];
            TX_DATA: tx_byte_d = wdata_q[{idx_d, 3'b000} +: 8];
            TX_CRC:  tx_byte_d = crc_d;
            default: tx_byte_d = 8'h00;
        endcase
        if (state_d == DONE && state != DONE) begin
            final_status = tout_d ? 8'hF1 : echo_bad_d ? 8'hF3 : crc_bad_d ? 8'hF2 : status_d;
            rsp_status_d = final_status;
            rsp_rdata_d  = (!write_q && final_status == 8'h00) ? rdata_d : 32'h0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0; crc <= '0; status_q <= '0; rdata_q <= '0; cnt <= '0;
            echo_bad <= 1'b0; crc_bad <= 1'b0; tout <= 1'b0;
            write_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
            tx_byte <= '0; tx_valid <= 1'b0; req_ready <= 1'b1; busy <= 1'b0;
            rsp_valid <= 1'b0; rsp_status <= '0; rsp_rdata <= '0;
        end else begin
            idx <= idx_d; crc <= crc_d; status_q <= status_d; rdata_q <= rdata_d; cnt <= cnt_d;
            echo_bad <= echo_bad_d; crc_bad <= crc_bad_d; tout <= tout_d;
            if (state == IDLE && req_valid) begin
                write_q <= req_write; addr_q <= req_addr; wdata_q <= req_wdata;
            end
            tx_byte <= tx_byte_d; tx_valid <= tx_valid_d; req_ready <= req_ready_d; busy <= busy_d;
            rsp_valid <= rsp_valid_d; rsp_status <= rsp_status_d; rsp_rdata <= rsp_rdata_d;
        end
    end
endmodule

// File: doc/uart_cmd_master.md
UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_250_000: response timeout in clk cycles.
REQ-002 Parameter SOF_TX, default 8'hA5: request start-of-frame byte.
REQ-003 Parameter SOF_RX, default 8'h5A: response start-of-frame byte.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid/req_ready  in/out  1/1  request handshake.
REQ-007 req_write  in  1  1=write, 0=read.
REQ-008 req_addr, req_wdata  in  32 each  target address and write data.
REQ-009 tx_byte/tx_valid/tx_ready  out/out/in  8/1/1  byte stream to the UART transmitter.
REQ-010 rx_byte/rx_valid  in  8/1  byte stream from the UART receiver; no backpressure.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_status, rsp_rdata  out  8/32  completion status and read data.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL use the states IDLE, TX_SOF, TX_CMD, TX_ADDR, TX_DATA, TX_CRC, RX_SOF, RX_STAT, RX_CMD, RX_DATA, RX_CRC and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready, latch req_write/addr/wdata and go to TX_SOF.
REQ-016 The request frame SHALL be SOF_TX, CMD, ADDR[7:0..31:24] (little-endian), WDATA in LE order for writes only, then CRC.
REQ-017 CMD SHALL be {~req_write, 1'b0, 2'b10, 4'h0}: 8'h20 for a write, 8'hA0 for a read.
REQ-018 A byte SHALL advance only on the cycle tx_valid&&tx_ready; tx_byte SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-019 A 2-bit byte index SHALL count ADDR and DATA bytes and wrap 3->0 on each state exit.
REQ-020 CRC SHALL be CRC-8, polynomial 0x07, init 0x00, MSB-first, computed over CMD through the last data byte and excluding SOF; one byte per cycle.
REQ-021 After the last TX byte is accepted, the block SHALL go to RX_SOF, clear the timeout counter and restart the RX CRC.
REQ-022 In RX_SOF, any rx byte other than SOF_RX SHALL be discarded.
REQ-023 In TX states, rx_valid SHALL be ignored.
REQ-024 The response frame SHALL be SOF_RX, STATUS, CMD echo, 4 LE data bytes (read with STATUS==0 only), then CRC over STATUS..last data byte.
REQ-025 In DONE, the block SHALL assert rsp_valid for exactly 1 cycle, then return to IDLE.
REQ-026 rsp_status SHALL be 8'hF3 if the CMD echo mismatches, else 8'hF2 on CRC mismatch, else the received STATUS.
REQ-027 rsp_rdata SHALL be assembled data for a read with STATUS 0, else 32'h0; both hold until the next DONE.
REQ-028 The timeout counter SHALL increment every cycle in RX states and SHALL be cleared by every accepted rx byte.
REQ-029 When the counter reaches TIMEOUT_CYCLES-1, the block SHALL go to DONE with rsp_status=8'hF1 and rsp_rdata=0.
REQ-030 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1); it SHALL saturate and never wrap.
REQ-031 If a timeout and an rx byte occur in the same cycle, the rx byte SHALL win.

Reset
REQ-032 On rst, outputs SHALL take: state=IDLE, req_ready=1, tx_valid=0, tx_byte=0, rsp_valid=0, rsp_status=0, rsp_rdata=0, busy=0, counters=0, CRC=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no rsp_valid pulse.

Configuration
REQ-034 With UART_CMD_CRC_EN defined, CRC bytes SHALL be sent and checked as specified above.
REQ-035 Without UART_CMD_CRC_EN, TX_CRC and RX_CRC SHALL be skipped, no CRC byte is sent or expected, and status 8'hF2 SHALL never occur.

Verification
REQ-036 Write 0x1000<=0x12345678, tx_ready=1, reply 5A 00 20 CRC -> TX A5 20 00 10 00 00 78 56 34 12 CRC; rsp_status=00.
REQ-037 Read 0x1004, reply 5A 00 A0 EF BE AD DE CRC -> rsp_rdata=0xDEADBEEF, status 00.
REQ-038 tx_ready toggling 1-of-3 cycles -> byte order unchanged and tx_byte stable while stalled.
REQ-039 No reply, TIMEOUT_CYCLES=100 -> rsp_valid exactly 100 cycles after last TX byte, status F1.
REQ-040 Corrupted reply CRC (CRC_EN) -> status F2; leading junk bytes 00 FF before SOF -> discarded, normal completion.
REQ-041 rst asserted during TX_ADDR -> tx_valid=0 immediately, no rsp_valid, req_ready=1 after release.
